// File: rtl/serial_word_shifter.sv
// Parallel-in/serial-out word shifter with a one-word holding register.
// It feeds a serial "11" sequence detector one bit per clock.
module serial_word_shifter #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             out,
  output logic             out_valid,
  output logic             word_done,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] shreg_r;
  logic [WIDTH-1:0] hold_r;
  logic [CW-1:0]    cnt_r;
  logic             hold_full_r;

  logic             accept_s;
  logic             last_bit_s;
  logic [WIDTH-1:0] shifted_s;
  logic             head_bit_s;

  // Handshake and shift-path decode, driven only by registered state and load_valid.
  always_comb begin
    accept_s   = load_valid && !hold_full_r;
    last_bit_s = (cnt_r == LAST_IDX);
    if (MSB_FIRST) begin
      shifted_s  = {shreg_r[WIDTH-2:0], 1'b0};
      head_bit_s = shreg_r[WIDTH-1];
    end else begin
      shifted_s  = {1'b0, shreg_r[WIDTH-1:1]};
      head_bit_s = shreg_r[0];
    end
  end

  // Shifter FSM: loads, shifts, and chains the held word in on the last-bit edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      shreg_r     <= {WIDTH{1'b0}};
      hold_r      <= {WIDTH{1'b0}};
      cnt_r       <= {CW{1'b0}};
      hold_full_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          hold_full_r <= 1'b0;
          cnt_r       <= {CW{1'b0}};
          if (accept_s) begin
            shreg_r <= data_in;
            state_r <= SHIFT;
          end else begin
            state_r <= IDLE;
          end
        end
        SHIFT: begin
          if (!last_bit_s) begin
            shreg_r <= shifted_s;
            cnt_r   <= cnt_r + CW'(1);
            if (accept_s) begin
              hold_r      <= data_in;
              hold_full_r <= 1'b1;
            end else begin
              hold_full_r <= hold_full_r;
            end
          end else if (hold_full_r) begin
            // load_ready is low here, so no new word can collide with the drain.
            shreg_r     <= hold_r;
            cnt_r       <= {CW{1'b0}};
            hold_full_r <= 1'b0;
          end else if (accept_s) begin
            shreg_r <= data_in;
            cnt_r   <= {CW{1'b0}};
          end else begin
            shreg_r <= {WIDTH{1'b0}};
            cnt_r   <= {CW{1'b0}};
            state_r <= IDLE;
          end
        end
        default: begin
          state_r     <= IDLE;
          shreg_r     <= {WIDTH{1'b0}};
          cnt_r       <= {CW{1'b0}};
          hold_full_r <= 1'b0;
        end
      endcase
    end
  end

  // Output decode straight from state registers, so reset clears them at once.
  always_comb begin
    load_ready = !hold_full_r;
    out_valid  = 1'b0;
    out        = 1'b0;
    word_done  = 1'b0;
    busy       = hold_full_r;
    if (state_r == SHIFT) begin
      out_valid = 1'b1;
      out       = head_bit_s;
      word_done = last_bit_s;
      busy      = 1'b1;
    end else begin
      out_valid = 1'b0;
    end
  end

endmodule

// File: tb/tb_serial_word_shifter.sv
// Bench for serial_word_shifter: bit-queue reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_serial_word_shifter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] din_m = 8'h00, din_l = 8'h00;
  logic       lv_m = 1'b0, lv_l = 1'b0;
  logic       rdy_m, out_m, ov_m, wd_m, busy_m;
  logic       rdy_l, out_l, ov_l, wd_l, busy_l;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  serial_word_shifter #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .reset(reset), .data_in(din_m), .load_valid(lv_m), .load_ready(rdy_m),
    .out(out_m), .out_valid(ov_m), .word_done(wd_m), .busy(busy_m));

  serial_word_shifter #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .reset(reset), .data_in(din_l), .load_valid(lv_l), .load_ready(rdy_l),
    .out(out_l), .out_valid(ov_l), .word_done(wd_l), .busy(busy_l));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: every accepted word appends its bits to a queue; one bit leaves per clock.
  bit q_m[$], f_m[$], q_l[$], f_l[$];
  bit acc_m, acc_l;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      q_m.delete(); f_m.delete(); q_l.delete(); f_l.delete();
    end else begin
      acc_m = lv_m && (q_m.size() <= 8);
      acc_l = lv_l && (q_l.size() <= 8);
      if (q_m.size() > 0) begin void'(q_m.pop_front()); void'(f_m.pop_front()); end
      if (q_l.size() > 0) begin void'(q_l.pop_front()); void'(f_l.pop_front()); end
      for (int b = 0; b < 8; b++) begin
        if (acc_m) begin q_m.push_back(din_m[7-b]); f_m.push_back(b == 7); end
        if (acc_l) begin q_l.push_back(din_l[b]);   f_l.push_back(b == 7); end
      end
    end
  end

  // Downstream "11" detector, sampling out on the shifter's own edge.
  logic seen1, det;
  always @(posedge clk or posedge reset) begin
    if (reset) begin seen1 <= 1'b0; det <= 1'b0; end
    else begin seen1 <= out_m; det <= seen1 && out_m; end
  end

  // Emitted-bit logs and run statistics, gathered by the compare process.
  logic log_m [0:255];
  logic log_l [0:255];
  int   n_m = 0, n_l = 0, cur_run = 0, max_run = 0, low_cnt = 0, done_pos = -1;
  int   det_n = 0;
  int   det_pos [0:7];

  // Compare process: DUT outputs against the model on every cycle out of reset.
  always @(negedge clk) begin
    if (!reset) begin
      check("out_m",   32'(out_m),  32'((q_m.size() > 0) ? q_m[0] : 1'b0));
      check("valid_m", 32'(ov_m),   32'(q_m.size() > 0));
      check("done_m",  32'(wd_m),   32'((q_m.size() > 0) ? f_m[0] : 1'b0));
      check("busy_m",  32'(busy_m), 32'(q_m.size() > 0));
      check("ready_m", 32'(rdy_m),  32'(q_m.size() <= 8));
      check("out_l",   32'(out_l),  32'((q_l.size() > 0) ? q_l[0] : 1'b0));
      check("valid_l", 32'(ov_l),   32'(q_l.size() > 0));
      check("done_l",  32'(wd_l),   32'((q_l.size() > 0) ? f_l[0] : 1'b0));
      check("busy_l",  32'(busy_l), 32'(q_l.size() > 0));
      check("ready_l", 32'(rdy_l),  32'(q_l.size() <= 8));
      if (ov_m) begin
        log_m[n_m[7:0]] = out_m;
        n_m++;
        cur_run++;
        if (cur_run > max_run) max_run = cur_run;
      end else begin
        cur_run = 0;
      end
      if (ov_l) begin log_l[n_l[7:0]] = out_l; n_l++; end
      if (!rdy_m) low_cnt++;
      if (wd_m) done_pos = n_m;
      if (det) begin
        if (det_n < 8) det_pos[det_n] = ov_m ? n_m - 1 : -1;
        det_n++;
      end
    end
  end

  function automatic logic [7:0] pack_m(input int base);
    logic [7:0] v;
    for (int b = 0; b < 8; b++) v[7-b] = log_m[base + b];
    return v;
  endfunction

  function automatic logic [7:0] pack_l(input int base);
    logic [7:0] v;
    for (int b = 0; b < 8; b++) v[7-b] = log_l[base + b];
    return v;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_stats();
    n_m = 0; n_l = 0; cur_run = 0; max_run = 0; low_cnt = 0; done_pos = -1; det_n = 0;
  endtask

  // Offer a word and hold it until an edge accepts it; counts edges that stalled.
  task automatic send_m(input logic [7:0] w, output int waits);
    bit r;
    int n;
    din_m = w; lv_m = 1'b1; waits = 0; n = 0;
    do begin
      r = rdy_m;
      tick();
      if (!r) waits++;
      n++;
    end while (!r && n < 64);
    if (!r) check("send_m_timeout", 32'(r), 32'd1);
  endtask

  task automatic send_l(input logic [7:0] w);
    bit r;
    int n;
    din_l = w; lv_l = 1'b1; n = 0;
    do begin
      r = rdy_l;
      tick();
      n++;
    end while (!r && n < 64);
    if (!r) check("send_l_timeout", 32'(r), 32'd1);
  endtask

  int w1, w2, w3;

  initial begin
    #1;
    check("rst_out",   32'({out_m, ov_m, wd_m, busy_m}), 32'd0);
    check("rst_ready", 32'(rdy_m), 32'd1);
    #5 reset = 1'b0;
    ticks(2);

    // 1: single MSB-first word
    clear_stats();
    send_m(8'hB4, w1); lv_m = 1'b0;
    ticks(10);
    check("t1_bits",  32'(pack_m(0)), 32'h0000_00B4);
    check("t1_nbits", 32'(n_m), 32'd8);
    check("t1_done",  32'(done_pos), 32'd8);
    check("t1_idle",  32'({out_m, ov_m}), 32'd0);

    // 4: LSB-first word, 8'h0D emits 1,0,1,1,0,0,0,0
    clear_stats();
    send_l(8'h0D); lv_l = 1'b0;
    ticks(10);
    check("t4_bits",  32'(pack_l(0)), 32'h0000_00B0);
    check("t4_nbits", 32'(n_l), 32'd8);

    // 2: back-to-back at full throughput
    clear_stats();
    send_m(8'hFF, w1); send_m(8'h00, w2); send_m(8'hA5, w3); lv_m = 1'b0;
    ticks(24);
    check("t2_w0",   32'(pack_m(0)),  32'h0000_00FF);
    check("t2_w1",   32'(pack_m(8)),  32'h0000_0000);
    check("t2_w2",   32'(pack_m(16)), 32'h0000_00A5);
    check("t2_run",  32'(max_run), 32'd24);
    check("t2_rlow", 32'(low_cnt), 32'd14);

    // 3: backpressure on the third word until the hold register drains
    clear_stats();
    send_m(8'hC3, w1); send_m(8'h5A, w2); send_m(8'h96, w3); lv_m = 1'b0;
    ticks(24);
    check("t3_wait1", 32'(w1), 32'd0);
    check("t3_wait2", 32'(w2), 32'd0);
    check("t3_wait3", 32'(w3), 32'd7);
    check("t3_w0",    32'(pack_m(0)),  32'h0000_00C3);
    check("t3_w1",    32'(pack_m(8)),  32'h0000_005A);
    check("t3_w2",    32'(pack_m(16)), 32'h0000_0096);
    check("t3_run",   32'(max_run), 32'd24);

    // 5: reset while bit 3 of the first of two words is on out
    clear_stats();
    send_m(8'hF0, w1); send_m(8'h3C, w2); lv_m = 1'b0;
    ticks(2);
    #1 reset = 1'b1;
    #1;
    check("t5_rst_out",   32'({out_m, ov_m, wd_m, busy_m}), 32'd0);
    check("t5_rst_ready", 32'(rdy_m), 32'd1);
    #2 reset = 1'b0;
    ticks(2);
    clear_stats();
    send_m(8'h81, w1); lv_m = 1'b0;
    ticks(12);
    check("t5_bits",  32'(pack_m(0)), 32'h0000_0081);
    check("t5_nbits", 32'(n_m), 32'd8);

    // 6: detector fires in the cycles after it samples bits 2 and 5 of 8'h6C
    clear_stats();
    send_m(8'h6C, w1); lv_m = 1'b0;
    ticks(12);
    check("t6_count", 32'(det_n), 32'd2);
    check("t6_pos0",  32'(det_pos[0]), 32'd3);
    check("t6_pos1",  32'(det_pos[1]), 32'd6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
